// File: rtl/ppu_sparse_compressor_pkg.sv
// Shared PPU types for the sparse compressor: pooled input beat, SCNN sparse entry/packet
// and the compressor FSM states.
package ppu_sparse_compressor_pkg;

    localparam int POOLING_OUT_SIZE = 4;
    localparam int ACC_K_OFFSET     = 16;
    localparam int KC_W             = $clog2(ACC_K_OFFSET);
    localparam int PPU_DW           = 16;
    localparam int SPARSE_IDX_WIDTH = 4;
    localparam int SPARSE_CNT_W     = $clog2(POOLING_OUT_SIZE + 1);

    typedef struct packed {
        logic [POOLING_OUT_SIZE-1:0]             valid;
        logic [POOLING_OUT_SIZE-1:0][PPU_DW-1:0] data;
    } PPU_compress_PACKET;

    typedef struct packed {
        logic [PPU_DW-1:0]           data;
        logic [SPARSE_IDX_WIDTH-1:0] idx;
    } SPARSE_ENTRY;

    typedef struct packed {
        SPARSE_ENTRY [POOLING_OUT_SIZE-1:0] entry;
        logic [SPARSE_CNT_W-1:0]            cnt;
        logic [KC_W-1:0]                    kc;
        logic                               last;
    } PPU_SPARSE_PACKET;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DRAIN,
        ST_DONE
    } sparse_state_e;

endpackage

// File: rtl/ppu_sparse_compressor_fifo.sv
// Packet FIFO with two ordered write ports (port 0 lands ahead of port 1) and one read port.
module sparse_pkt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr0_en_i,
    input  logic [W-1:0] wr0_data_i,
    input  logic         wr1_en_i,
    input  logic [W-1:0] wr1_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         rd_valid_o,
    output logic         empty_o,
    output logic         drop0_o,
    output logic         drop1_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr1;
    logic [CW-1:0] count_q, count_d, space;
    logic          pop, acc0, acc1;

    assign pop     = rd_en_i && (count_q != '0);
    // A same-cycle pop frees its slot before either push is admitted.
    assign space   = CW'(DEPTH) - count_q + CW'(pop);
    assign acc0    = wr0_en_i && (space != '0);
    assign acc1    = wr1_en_i && (space > CW'(acc0));
    assign drop0_o = wr0_en_i && !acc0;
    assign drop1_o = wr1_en_i && !acc1;

    assign wptr1   = wptr_q + AW'(acc0);
    assign wptr_d  = wptr_q + AW'(acc0) + AW'(acc1);
    assign rptr_d  = rptr_q + AW'(pop);
    assign count_d = count_q + CW'(acc0) + CW'(acc1) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc0) mem_q[wptr_q] <= wr0_data_i;
        if (acc1) mem_q[wptr1]  <= wr1_data_i;
    end

    assign rd_data_o  = mem_q[rptr_q];
    assign rd_valid_o = (count_q != '0);
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/ppu_sparse_compressor.sv
// Re-encodes pooled beats into SCNN sparse entries (value, zero-run), compacts them into
// lane-packed packets and queues them, with channel-end markers, toward write-back.
module ppu_sparse_compressor
    import ppu_sparse_compressor_pkg::*;
#(
    parameter int LANES      = POOLING_OUT_SIZE,
    parameter int DW         = PPU_DW,
    parameter int IDX_W      = SPARSE_IDX_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  PPU_compress_PACKET            in_pkt,
    input  logic [KC_W-1:0]               in_kc,
    input  logic                          in_finish,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0][DW-1:0]      out_data,
    output logic [LANES-1:0][IDX_W-1:0]   out_idx,
    output logic [$clog2(LANES+1)-1:0]    out_cnt,
    output logic [KC_W-1:0]               out_kc,
    output logic                          out_last,
    output logic                          overflow,
    output logic                          done
);
    localparam int CNT_W = $clog2(LANES + 1);
    localparam int LW    = $clog2(LANES);
    localparam logic [IDX_W-1:0] RUN_MAX = '1;

    sparse_state_e               state_q, state_d;
    logic [IDX_W-1:0]            run_q, run_d, run_c;
    logic [KC_W-1:0]             kc_q, kc_d;
    logic                        fin_pend_q, fin_pend_d, ovf_q, ovf_d;
    logic                        beat, fresh;
    logic [LANES-1:0]            emit;
    logic [LANES-1:0][IDX_W-1:0] lane_idx;
    logic [LANES-1:0][LW-1:0]    pos;
    logic [CNT_W-1:0]            n_emit;
    PPU_SPARSE_PACKET            data_pkt, mark_pkt, fifo_head, head;
    logic                        wr0_en, wr1_en, fifo_valid, fifo_empty, drop0, drop1;

    assign beat  = |in_pkt.valid;
    assign fresh = (state_q == ST_IDLE) || (in_kc != kc_q);

    // Zero-run walk across the valid lanes in ascending order; invalid lanes are transparent.
    always_comb begin
        run_c    = fresh ? '0 : run_q;
        emit     = '0;
        lane_idx = '0;
        for (int l = 0; l < LANES; l++) begin
            if (in_pkt.valid[l]) begin
                lane_idx[l] = run_c;
                if ((in_pkt.data[l] != '0) || (run_c == RUN_MAX)) begin
                    emit[l] = 1'b1;
                    run_c   = '0;
                end else begin
                    run_c = run_c + 1'b1;
                end
            end
        end
    end

    always_comb begin
        n_emit = '0;
        pos    = '0;
        for (int l = 0; l < LANES; l++) begin
            pos[l] = n_emit[LW-1:0];
            n_emit = n_emit + CNT_W'(emit[l]);
        end
    end

    always_comb begin
        data_pkt = '0;
        for (int l = 0; l < LANES; l++) begin
            if (emit[l]) begin
                data_pkt.entry[pos[l]].data = in_pkt.data[l];
                data_pkt.entry[pos[l]].idx  = lane_idx[l];
            end
        end
        data_pkt.cnt  = n_emit;
        data_pkt.kc   = in_kc;
        data_pkt.last = 1'b0;
        mark_pkt      = '0;
        mark_pkt.kc   = kc_q;
        mark_pkt.last = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        kc_d       = kc_q;
        fin_pend_d = fin_pend_q;
        ovf_d      = ovf_q | drop0 | drop1;
        wr0_en     = 1'b0;
        wr1_en     = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (beat) begin
                    wr0_en  = (state_q == ST_ACTIVE) && (in_kc != kc_q);
                    wr1_en  = (n_emit != '0);
                    kc_d    = in_kc;
                    run_d   = run_c;
                    state_d = ST_ACTIVE;
                    // A finish arriving with a beat defers its marker by one cycle.
                    if (in_finish) begin
                        fin_pend_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end else if (in_finish) begin
                    wr0_en  = (state_q == ST_ACTIVE);
                    state_d = (state_q == ST_ACTIVE) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (beat) ovf_d = 1'b1;
                if (fin_pend_q) begin
                    wr0_en     = 1'b1;
                    fin_pend_d = 1'b0;
                end else if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (beat) ovf_d = 1'b1;
                run_d      = '0;
                kc_d       = '0;
                fin_pend_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            run_q      <= '0;
            kc_q       <= '0;
            fin_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            kc_q       <= kc_d;
            fin_pend_q <= fin_pend_d;
            ovf_q      <= ovf_d;
        end
    end

    sparse_pkt_fifo #(
        .W     ($bits(PPU_SPARSE_PACKET)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .wr0_en_i   (wr0_en),
        .wr0_data_i (mark_pkt),
        .wr1_en_i   (wr1_en),
        .wr1_data_i (data_pkt),
        .rd_en_i    (out_ready),
        .rd_data_o  (fifo_head),
        .rd_valid_o (fifo_valid),
        .empty_o    (fifo_empty),
        .drop0_o    (drop0),
        .drop1_o    (drop1)
    );

    // Outputs read zero whenever the head is empty, including throughout reset.
    assign head = fifo_valid ? fifo_head : '0;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            out_data[l] = head.entry[l].data;
            out_idx[l]  = head.entry[l].idx;
        end
    end

    assign out_valid = fifo_valid;
    assign out_cnt   = head.cnt;
    assign out_kc    = head.kc;
    assign out_last  = head.last;
    assign overflow  = ovf_q;
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_ppu_sparse_compressor.sv
// Directed bench for ppu_sparse_compressor: a queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_ppu_sparse_compressor;
    import ppu_sparse_compressor_pkg::*;

    localparam int L     = 4;
    localparam int DEPTH = 4;
    localparam int M_IDLE = 0, M_ACTIVE = 1, M_DRAIN = 2, M_DONE = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    PPU_compress_PACKET   in_pkt;
    logic [KC_W-1:0]      in_kc;
    logic                 in_finish, out_ready;
    logic                 out_valid, out_last, overflow, done;
    logic [L-1:0][15:0]   out_data;
    logic [L-1:0][3:0]    out_idx;
    logic [2:0]           out_cnt;
    logic [KC_W-1:0]      out_kc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ppu_sparse_compressor dut (
        .clk       (clk),
        .rst       (rst),
        .in_pkt    (in_pkt),
        .in_kc     (in_kc),
        .in_finish (in_finish),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_cnt   (out_cnt),
        .out_kc    (out_kc),
        .out_last  (out_last),
        .overflow  (overflow),
        .done      (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what the packet stream must be, from the encoding rules.
    PPU_SPARSE_PACKET mq[$];
    int               m_mode = M_IDLE;
    int               m_run  = 0;
    logic [KC_W-1:0]  m_kc   = '0;
    bit               m_pend = 0, m_ovf = 0, m_done = 0, m_was_empty;

    task automatic m_push(input PPU_SPARSE_PACKET p);
        if (mq.size() < DEPTH) mq.push_back(p);
        else m_ovf = 1;
    endtask

    task automatic m_marker(input logic [KC_W-1:0] kc);
        PPU_SPARSE_PACKET p;
        p      = '0;
        p.kc   = kc;
        p.last = 1'b1;
        m_push(p);
    endtask

    task automatic m_beat();
        PPU_SPARSE_PACKET p;
        int n;
        p = '0;
        n = 0;
        for (int l = 0; l < L; l++) begin
            if (in_pkt.valid[l]) begin
                if (in_pkt.data[l] != 0) begin
                    p.entry[n].data = in_pkt.data[l];
                    p.entry[n].idx  = 4'(m_run);
                    n++;
                    m_run = 0;
                end else if (m_run == 15) begin
                    p.entry[n].data = 16'd0;
                    p.entry[n].idx  = 4'd15;
                    n++;
                    m_run = 0;
                end else begin
                    m_run++;
                end
            end
        end
        p.cnt = 3'(n);
        p.kc  = in_kc;
        if (n > 0) m_push(p);
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_mode = M_IDLE; m_run = 0; m_kc = '0; m_pend = 0; m_ovf = 0; m_done = 0;
        end else begin
            m_was_empty = (mq.size() == 0);
            if (!m_was_empty && out_ready) void'(mq.pop_front());
            case (m_mode)
                M_IDLE, M_ACTIVE: begin
                    if (|in_pkt.valid) begin
                        if (m_mode == M_IDLE) begin
                            m_kc = in_kc; m_run = 0;
                        end else if (in_kc != m_kc) begin
                            m_marker(m_kc);
                            m_kc = in_kc; m_run = 0;
                        end
                        m_beat();
                        m_mode = M_ACTIVE;
                        if (in_finish) begin m_pend = 1; m_mode = M_DRAIN; end
                    end else if (in_finish) begin
                        if (m_mode == M_ACTIVE) begin m_marker(m_kc); m_mode = M_DRAIN; end
                        else m_mode = M_DONE;
                    end
                end
                M_DRAIN: begin
                    if (|in_pkt.valid) m_ovf = 1;
                    if (m_pend) begin m_marker(m_kc); m_pend = 0; end
                    else if (m_was_empty) m_mode = M_DONE;
                end
                default: begin
                    if (|in_pkt.valid) m_ovf = 1;
                    m_run = 0; m_kc = '0; m_pend = 0; m_mode = M_IDLE;
                end
            endcase
            m_done = (m_mode == M_DONE);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    PPU_SPARSE_PACKET c_exp;
    bit               c_ok;
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_overflow", overflow, 0);
            check("rst_done", done, 0);
        end else begin
            check("out_valid", out_valid, 64'(mq.size() != 0));
            if (out_valid && mq.size() != 0) begin
                c_exp = mq[0];
                c_ok  = (out_cnt == c_exp.cnt) && (out_kc == c_exp.kc) && (out_last == c_exp.last);
                for (int l = 0; l < L; l++)
                    if (l < int'(c_exp.cnt))
                        c_ok &= (out_data[l] == c_exp.entry[l].data) && (out_idx[l] == c_exp.entry[l].idx);
                checks++;
                if (!c_ok) begin
                    errors++;
                    $display("FAIL head: got cnt=%0d kc=%0d last=%0b data=%h idx=%h, expected cnt=%0d kc=%0d last=%0b entries=%h",
                             out_cnt, out_kc, out_last, out_data, out_idx, c_exp.cnt, c_exp.kc, c_exp.last, c_exp.entry);
                end
            end
            check("overflow", overflow, 64'(m_ovf));
            check("done", done, 64'(m_done));
        end
    end

    task automatic drive(input logic [3:0] v, input int d0, input int d1, input int d2, input int d3,
                         input int kc, input bit fin);
        in_pkt.valid   = v;
        in_pkt.data[0] = 16'(d0);
        in_pkt.data[1] = 16'(d1);
        in_pkt.data[2] = 16'(d2);
        in_pkt.data[3] = 16'(d3);
        in_kc          = KC_W'(kc);
        in_finish      = fin;
        @(posedge clk); #1;
        in_pkt    = '0;
        in_finish = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int n;

    initial begin
        in_pkt = '0; in_kc = '0; in_finish = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_cnt", out_cnt, 0);
        check("reset_done", done, 0);
        rst = 1'b1;
        idle(1);

        // Scenario 1: {5,0,0,7} -> (5,0),(7,2)
        drive(4'b1111, 5, 0, 0, 7, 0, 0);
        check("s1_valid", out_valid, 1);
        check("s1_cnt", out_cnt, 2);
        check("s1_d0", out_data[0], 5);
        check("s1_d1", out_data[1], 7);
        check("s1_i0", out_idx[0], 0);
        check("s1_i1", out_idx[1], 2);
        check("s1_last", out_last, 0);
        idle(1);

        // Scenario 2: 20 zeros then 3 -> max-run entry (0,15), then (3,4)
        for (int b = 0; b < 3; b++) begin
            drive(4'b1111, 0, 0, 0, 0, 0, 0);
            check("s2_no_pkt", out_valid, 0);
        end
        drive(4'b1111, 0, 0, 0, 0, 0, 0);
        check("s2_ph_cnt", out_cnt, 1);
        check("s2_ph_data", out_data[0], 0);
        check("s2_ph_idx", out_idx[0], 15);
        drive(4'b1111, 0, 0, 0, 0, 0, 0);
        check("s2_no_pkt5", out_valid, 0);
        drive(4'b0001, 3, 0, 0, 0, 0, 0);
        check("s2_d0", out_data[0], 3);
        check("s2_i0", out_idx[0], 4);
        idle(1);

        // Scenario 3: channel change inserts a marker for the old channel
        drive(4'b1111, 1, 0, 0, 0, 0, 0);
        check("s3_a_d0", out_data[0], 1);
        check("s3_a_i0", out_idx[0], 0);
        drive(4'b1111, 0, 2, 0, 0, 1, 0);
        check("s3_mk_cnt", out_cnt, 0);
        check("s3_mk_last", out_last, 1);
        check("s3_mk_kc", out_kc, 0);
        idle(1);
        check("s3_b_d0", out_data[0], 2);
        check("s3_b_i0", out_idx[0], 1);
        check("s3_b_kc", out_kc, 1);
        idle(2);

        // Scenario 4: back-pressure, FIFO fills, 5th beat overflows
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive(4'b1111, 10*k+1, 10*k+2, 10*k+3, 10*k+4, 1, 0);
            check("s4_head_stable", out_data[0], 11);
            if (k == 4) check("s4_ovf_before", overflow, 0);
            if (k == 5) check("s4_ovf_after", overflow, 1);
        end
        idle(2);
        check("s4_hold_cnt", out_cnt, 4);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("s4_drain_order", out_data[0], 64'(10*k+1));
            idle(1);
        end
        check("s4_empty", out_valid, 0);
        rst = 1'b0;
        #1;
        check("s4_rst_ovf", overflow, 0);
        idle(1);
        rst = 1'b1;
        idle(1);

        // Scenario 5: two channels, finish, drain, done
        out_ready = 1'b0;
        drive(4'b0001, 4, 0, 0, 0, 2, 0);
        drive(4'b1111, 0, 0, 6, 0, 3, 0);
        drive(4'b0000, 0, 0, 0, 0, 3, 1);
        check("s5_ovf_pre", overflow, 0);
        drive(4'b1111, 9, 9, 9, 9, 3, 0);
        check("s5_ovf_drain", overflow, 1);
        check("s5_no_done", done, 0);
        out_ready = 1'b1;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("s5_done_seen", done, 1);
        check("s5_done_cycle", n, 5);
        check("s5_done_empty", out_valid, 0);
        idle(1);
        check("s5_done_pulse", done, 0);

        // Scenario 6: reset in the middle of DRAIN
        out_ready = 1'b0;
        drive(4'b1111, 1, 2, 3, 4, 0, 0);
        drive(4'b0001, 5, 0, 0, 0, 0, 0);
        drive(4'b0000, 0, 0, 0, 0, 0, 1);
        drive(4'b0001, 8, 0, 0, 0, 0, 0);
        check("s6_pre_valid", out_valid, 1);
        check("s6_pre_ovf", overflow, 1);
        #2;
        rst = 1'b0;
        #1;
        check("s6_rst_valid", out_valid, 0);
        check("s6_rst_ovf", overflow, 0);
        check("s6_rst_done", done, 0);
        check("s6_rst_cnt", out_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        drive(4'b1111, 5, 0, 0, 7, 0, 0);
        check("s6_cnt", out_cnt, 2);
        check("s6_d1", out_data[1], 7);
        check("s6_i1", out_idx[1], 2);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
